fpu_rr_scheduler: RTL and testbench

Shares one FPU_TOP instance among NUM_REQ requesters. Each requester uses its own valid/ready request channel. Arbitration is round-robin, one operation in flight at a time. The block holds operands stable to the FPU for FPU_LAT cycles, captures Result/NaN_error, and returns them on a single valid/ready response channel tagged with the requester ID. It sits between the client blocks and the shared FPU_TOP.

---
 rtl/fpu_rr_scheduler_if.sv | 31 +++
 rtl/fpu_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_fpu_rr_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_rr_scheduler_if.sv
// rtl/fpu_rr_scheduler_if.sv - request, response and FPU-side bundle of the shared FPU scheduler
interface fpu_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_A;
  logic [NUM_REQ*32-1:0] req_B;
  logic [NUM_REQ*2-1:0]  req_Opcode;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_Result;
  logic                  rsp_NaN_error;
  logic [31:0]           fpu_A;
  logic [31:0]           fpu_B;
  logic [1:0]            fpu_Opcode;
  logic [31:0]           fpu_Result;
  logic                  fpu_NaN_error;

  modport master (
    output req_valid, req_A, req_B, req_Opcode, rsp_ready, fpu_Result, fpu_NaN_error,
    input  req_ready, rsp_valid, rsp_id, rsp_Result, rsp_NaN_error, fpu_A, fpu_B, fpu_Opcode
  );

  modport slave (
    input  req_valid, req_A, req_B, req_Opcode, rsp_ready, fpu_Result, fpu_NaN_error,
    output req_ready, rsp_valid, rsp_id, rsp_Result, rsp_NaN_error, fpu_A, fpu_B, fpu_Opcode
  );
endinterface

// File: rtl/fpu_rr_scheduler.sv
// rtl/fpu_rr_scheduler.sv - round-robin sharing of one FPU among NUM_REQ requesters, one op in flight
module fpu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  fpu_rr_scheduler_if.slave   bus,
  output logic                busy
);
  localparam int CNT_W = $clog2(FPU_LAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic              rst_s_n;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]        op_q, op_d;
  logic              nan_q, nan_d;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;

  // Reset asserts asynchronously but is released on a clock edge.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= sync_d;
  end

  assign rst_s_n = sync_q[1];

  // Scan downward so the nearest requester after last_q is the one that sticks.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state_q  <= IDLE;
      last_q   <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      rsp_id_q <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      nan_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      nan_q    <= nan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = EXEC;
      EXEC:    if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d   = last_q;
    id_d     = id_q;
    rsp_id_d = rsp_id_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    nan_d    = nan_q;
    if (state_q == IDLE && gnt_vld) begin
      a_d    = bus.req_A[32*gnt_idx +: 32];
      b_d    = bus.req_B[32*gnt_idx +: 32];
      op_d   = bus.req_Opcode[2*gnt_idx +: 2];
      last_d = gnt_idx;
      id_d   = gnt_idx;
      cnt_d  = CNT_W'(FPU_LAT);
    end else if (state_q == EXEC) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        res_d    = bus.fpu_Result;
        nan_d    = bus.fpu_NaN_error;
        rsp_id_d = id_q;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && gnt_vld && rst_s_n) bus.req_ready = NUM_REQ'(1) << gnt_idx;
    bus.rsp_valid = (state_q == RESP);
    busy          = (state_q != IDLE);
  end

  assign bus.fpu_A         = a_q;
  assign bus.fpu_B         = b_q;
  assign bus.fpu_Opcode    = op_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_Result    = res_q;
  assign bus.rsp_NaN_error = nan_q;
endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// tb/tb_fpu_rr_scheduler.sv - directed and random checks of fpu_rr_scheduler against a cycle-level reference model
module tb_fpu_rr_scheduler;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  fpu_rr_scheduler_if #(.NUM_REQ(N), .ID_W(IDW)) ifc ();

  fpu_rr_scheduler #(.NUM_REQ(N), .FPU_LAT(LAT), .ID_W(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave),
    .busy (busy)
  );

  // Stand-in FPU: a few real IEEE results, a scramble otherwise.
  function automatic logic [31:0] fpu_fn(logic [31:0] x, logic [31:0] y, logic [1:0] o);
    if (o == 2'd0 && x == 32'h3FC00000 && y == 32'h3F800000) return 32'h40200000;
    if (o == 2'd2 && x == 32'h3FC00000 && y == 32'h40000000) return 32'h40400000;
    return (x ^ {y[15:0], y[31:16]}) + {30'd0, o};
  endfunction

  function automatic logic nan_fn(logic [31:0] x, logic [31:0] y, logic [1:0] o);
    return (o == 2'd3 && y[30:0] == 31'd0) || (x[30:23] == 8'hFF);
  endfunction

  // Result is only meaningful once operands have been held for LAT-1 full cycles.
  logic [31:0] pa = '0, pb = '0;
  logic [1:0]  po = '0;
  int          held = 0;

  always @(posedge clk) begin
    if ({ifc.fpu_A, ifc.fpu_B, ifc.fpu_Opcode} == {pa, pb, po}) held <= held + 1;
    else                                                        held <= 1;
    pa <= ifc.fpu_A;
    pb <= ifc.fpu_B;
    po <= ifc.fpu_Opcode;
  end

  always_comb begin
    if ({ifc.fpu_A, ifc.fpu_B, ifc.fpu_Opcode} == {pa, pb, po} && held >= LAT - 1) begin
      ifc.fpu_Result    = fpu_fn(ifc.fpu_A, ifc.fpu_B, ifc.fpu_Opcode);
      ifc.fpu_NaN_error = nan_fn(ifc.fpu_A, ifc.fpu_B, ifc.fpu_Opcode);
    end else begin
      ifc.fpu_Result    = 32'hDEADBEEF;
      ifc.fpu_NaN_error = 1'b1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          outstanding = 0;
  int          acc_cyc = 0;
  int          exp_id = 0;
  logic [31:0] e_a, e_b;
  logic [1:0]  e_op;
  int          mlast = N - 1;
  bit          rearm = 0;
  bit          want [N];
  logic [31:0] a [N];
  logic [31:0] b [N];
  logic [1:0]  op [N];
  int          gq [$];
  int          gcyc [$];
  logic [31:0] last_res;
  int          last_id;
  int          rsp_count = 0;
  logic [31:0] res_by_id [N];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(int last);
    for (int k = 1; k <= N; k++)
      if (want[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_rsp_valid"}, 32'(ifc.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(ifc.rsp_id), 32'd0);
    chk({tag, "_rsp_result"}, ifc.rsp_Result, 32'd0);
    chk({tag, "_rsp_nan"}, 32'(ifc.rsp_NaN_error), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_ready"}, 32'(ifc.req_ready), 32'd0);
    chk({tag, "_fpu_a"}, ifc.fpu_A, 32'd0);
    chk({tag, "_fpu_b"}, ifc.fpu_B, 32'd0);
    chk({tag, "_fpu_op"}, 32'(ifc.fpu_Opcode), 32'd0);
  endtask

  // One clock: drive, check against the model, advance the model, cross the edge.
  task automatic step();
    bit          exp_rv;
    int          pick;
    logic [N-1:0] exp_rdy;
    if (rearm) for (int i = 0; i < N; i++) want[i] = 1'b1;
    for (int i = 0; i < N; i++) begin
      ifc.req_valid[i]          = want[i];
      ifc.req_A[32*i +: 32]     = a[i];
      ifc.req_B[32*i +: 32]     = b[i];
      ifc.req_Opcode[2*i +: 2]  = op[i];
    end
    #1;
    exp_rv = outstanding && (cyc >= acc_cyc + LAT + 1);
    chk("busy", 32'(busy), 32'(outstanding));
    chk("rsp_valid", 32'(ifc.rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 32'(ifc.rsp_id), 32'(exp_id));
      chk("rsp_result", ifc.rsp_Result, fpu_fn(e_a, e_b, e_op));
      chk("rsp_nan", 32'(ifc.rsp_NaN_error), 32'(nan_fn(e_a, e_b, e_op)));
    end
    if (outstanding) begin
      chk("fpu_a", ifc.fpu_A, e_a);
      chk("fpu_b", ifc.fpu_B, e_b);
      chk("fpu_op", 32'(ifc.fpu_Opcode), 32'(e_op));
    end
    pick    = outstanding ? -1 : rr_pick(mlast);
    exp_rdy = (pick >= 0) ? (N'(1) << pick) : '0;
    chk("req_ready", 32'(ifc.req_ready), 32'(exp_rdy));
    if (pick >= 0) begin
      outstanding = 1;
      acc_cyc     = cyc;
      exp_id      = pick;
      e_a         = a[pick];
      e_b         = b[pick];
      e_op        = op[pick];
      mlast       = pick;
      want[pick]  = 1'b0;
      gq.push_back(pick);
      gcyc.push_back(cyc);
    end else if (exp_rv && ifc.rsp_ready) begin
      outstanding = 0;
      last_res    = ifc.rsp_Result;
      last_id     = int'(ifc.rsp_id);
      res_by_id[exp_id] = ifc.rsp_Result;
      rsp_count++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_grants(string tag, int target, int bound);
    for (int k = 0; k < bound && gq.size() < target; k++) step();
    chk({tag, "_timeout"}, 32'(gq.size() >= target), 32'd1);
  endtask

  task automatic run_idle(string tag, int bound);
    for (int k = 0; k < bound && outstanding; k++) step();
    chk({tag, "_timeout"}, 32'(outstanding), 32'd0);
  endtask

  initial begin
    int base;
    int rc;
    for (int i = 0; i < N; i++) begin
      want[i] = 0; a[i] = '0; b[i] = '0; op[i] = '0; res_by_id[i] = '0;
    end
    ifc.req_valid = '0; ifc.req_A = '0; ifc.req_B = '0; ifc.req_Opcode = '0;
    ifc.rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) step();
    chk_zero("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // single add
    a[0] = 32'h3FC00000; b[0] = 32'h3F800000; op[0] = 2'd0; want[0] = 1;
    run_grants("single_grant", 1, 10);
    run_idle("single_done", 10);
    chk("single_id", 32'(last_id), 32'd0);
    chk("single_result", last_res, 32'h40200000);

    // all requesters continuously valid
    a[1] = 32'h40000000; b[1] = 32'h3F800000; op[1] = 2'd1;
    a[2] = 32'h3FC00000; b[2] = 32'h40000000; op[2] = 2'd2;
    a[3] = 32'h40800000; b[3] = 32'h40000000; op[3] = 2'd3;
    base  = gq.size();
    rearm = 1;
    run_grants("rr_grants", base + 5, 60);
    rearm = 0;
    for (int i = 0; i < N; i++) want[i] = 0;
    run_idle("rr_done", 10);
    chk("rr_first", 32'(gq[base]), 32'd1);
    for (int k = 1; k < 5; k++) begin
      chk("rr_order", 32'(gq[base+k]), 32'((gq[base+k-1] + 1) % N));
      chk("rr_spacing", 32'(gcyc[base+k] - gcyc[base+k-1]), 32'(LAT + 2));
    end
    chk("rr_mul_result", res_by_id[2], 32'h40400000);

    // pointer wrap after a grant to 3
    want[3] = 1;
    run_grants("wrap_g3", gq.size() + 1, 10);
    want[1] = 1; want[3] = 1;
    base = gq.size();
    run_grants("wrap_pair", base + 2, 20);
    chk("wrap_first", 32'(gq[base]), 32'd1);
    chk("wrap_second", 32'(gq[base+1]), 32'd3);
    run_idle("wrap_done", 10);

    // response backpressure
    ifc.rsp_ready = 1'b0;
    want[0] = 1;
    run_grants("bp_grant", gq.size() + 1, 10);
    for (int k = 0; k < 10 && !ifc.rsp_valid; k++) step();
    want[2] = 1;
    for (int k = 0; k < 10; k++) step();
    rc = rsp_count;
    ifc.rsp_ready = 1'b1;
    step();
    chk("bp_complete", 32'(rsp_count), 32'(rc + 1));
    chk("bp_rsp_drop", 32'(ifc.rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(ifc.req_ready), 32'b0100);
    run_grants("bp_g2", gq.size() + 1, 5);
    run_idle("bp_done", 10);

    // operands change after acceptance
    a[1] = 32'h3FC00000; b[1] = 32'h3F800000; op[1] = 2'd0; want[1] = 1;
    run_grants("stab_grant", gq.size() + 1, 10);
    a[1] = $urandom; b[1] = $urandom;
    run_idle("stab_done", 10);
    chk("stab_id", 32'(last_id), 32'd1);
    chk("stab_result", last_res, 32'h40200000);

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(0, 3) == 0) begin
          want[i] = 1; a[i] = $urandom; b[i] = $urandom; op[i] = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 7) == 0) b[i][30:0] = '0;
        end
      end
      ifc.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    for (int i = 0; i < N; i++) want[i] = 0;
    ifc.rsp_ready = 1'b1;
    run_idle("rand_drain", 20);

    // reset in the last EXEC cycle
    a[2] = 32'h12345678; b[2] = 32'h3F800000; op[2] = 2'd2; want[2] = 1;
    run_grants("rst_grant", gq.size() + 1, 10);
    step();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_exec");
    outstanding = 0;
    mlast = N - 1;
    for (int i = 0; i < N; i++) want[i] = 0;
    for (int k = 0; k < 2; k++) step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    want[0] = 1; want[2] = 1; want[3] = 1;
    a[0] = 32'h3FC00000; b[0] = 32'h3F800000; op[0] = 2'd0;
    base = gq.size();
    run_grants("rst_regrant", base + 1, 10);
    chk("rst_first_grant", 32'(gq[base]), 32'd0);
    for (int i = 0; i < N; i++) want[i] = 0;
    run_idle("rst_done", 10);
    chk("rst_result", last_res, 32'h40200000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
